// File: rtl/alu_seq_muldiv_pkg.sv
// Shared constants for the sequential multiply/divide controller:
// external ALU opcodes, FSM state encoding and request op encoding.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MUL = 1'b0,
    DIV = 1'b1
  } op_sel_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle shift-add multiplier / restoring divider that borrows an external N-bit ALU.
// Define ALU_SEQ_DIV_EN to enable the divide datapath; otherwise every request is a multiply.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] res_hi_o,
  output logic [N-1:0] res_lo_o,
  output logic         div0_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [2:0]   alu_op_o,
  output logic         alu_inv_o,
  output logic         alu_c_o,
  input  logic [N-1:0] alu_res_i,
  input  logic         alu_cout_i
);

  localparam int CNT_W = $clog2(N) + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     hi, lo, m;
  logic [N-1:0]     hi_nxt, lo_nxt;
  logic             last_step;

`ifdef ALU_SEQ_DIV_EN
  op_sel_t          op_q;
  logic             div0_q;
  logic [N-1:0]     t;
  logic             ok;
`else
  logic             unused_op;
  assign unused_op = op_i;
`endif

  assign last_step = (cnt == CNT_W'(N - 1));
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // One ALU add/subtract per STEP cycle; the ALU result feeds the next register values.
  always_comb begin
    state_nxt = state;
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_op_o  = OP_ADD;
    alu_inv_o = 1'b0;
    alu_c_o   = 1'b0;
    hi_nxt    = hi;
    lo_nxt    = lo;
`ifdef ALU_SEQ_DIV_EN
    t         = '0;
    ok        = 1'b0;
`endif
    case (state)
      IDLE: if (start_i) state_nxt = STEP;
      STEP: begin
        if (last_step) state_nxt = DONE;
        alu_a_o = hi;
        alu_b_o = m;
        if (lo[0]) {hi_nxt, lo_nxt} = {alu_cout_i, alu_res_i, lo[N-1:1]};
        else       {hi_nxt, lo_nxt} = {1'b0, hi, lo[N-1:1]};
`ifdef ALU_SEQ_DIV_EN
        // Restoring divide: trial subtract of the divisor from the shifted remainder.
        if (op_q == DIV) begin
          t         = {hi[N-2:0], lo[N-1]};
          alu_a_o   = t;
          alu_inv_o = 1'b1;
          alu_c_o   = 1'b1;
          ok        = hi[N-1] | alu_cout_i;
          if (ok) begin
            hi_nxt = alu_res_i;
            lo_nxt = {lo[N-2:0], 1'b1};
          end else begin
            hi_nxt = t;
            lo_nxt = {lo[N-2:0], 1'b0};
          end
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are copied out on the final step so they stay stable until the next completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      res_hi_o <= '0;
      res_lo_o <= '0;
`ifdef ALU_SEQ_DIV_EN
      op_q     <= MUL;
      div0_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start_i) begin
        cnt <= '0;
        hi  <= '0;
        lo  <= a_i;
        m   <= b_i;
`ifdef ALU_SEQ_DIV_EN
        op_q   <= op_sel_t'(op_i);
        div0_q <= (op_sel_t'(op_i) == DIV) && (b_i == '0);
`endif
      end else if (state == STEP) begin
        cnt <= cnt + 1'b1;
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        if (last_step) begin
          res_hi_o <= hi_nxt;
          res_lo_o <= lo_nxt;
        end
      end
    end
  end

`ifdef ALU_SEQ_DIV_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                            div0_o <= 1'b0;
    else if (state == STEP && last_step)  div0_o <= div0_q;
  end
`else
  assign div0_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv with a behavioural N=8 ALU and an expected-result queue.
// Divide scenarios are exercised only when ALU_SEQ_DIV_EN is defined.
module tb_alu_seq_muldiv;
  import alu_seq_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op_sel;
  logic [N-1:0] a, b;
  logic         busy, done, div0;
  logic [N-1:0] res_hi, res_lo;
  logic [N-1:0] alu_a, alu_b, alu_res, alu_bb;
  logic [2:0]   alu_op;
  logic         alu_inv, alu_c, alu_cout;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         div0;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq_muldiv #(.N(N)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op_sel),
    .a_i(a), .b_i(b), .busy_o(busy), .done_o(done),
    .res_hi_o(res_hi), .res_lo_o(res_lo), .div0_o(div0),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_inv_o(alu_inv), .alu_c_o(alu_c),
    .alu_res_i(alu_res), .alu_cout_i(alu_cout)
  );

  // Behavioural model of the team's combinational ALU.
  always_comb begin
    alu_bb   = alu_inv ? ~alu_b : alu_b;
    alu_res  = '0;
    alu_cout = 1'b0;
    case (alu_op)
      OP_AND: alu_res = alu_a & alu_bb;
      OP_OR:  alu_res = alu_a | alu_bb;
      OP_ADD: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_bb} + {{N{1'b0}}, alu_c};
      OP_SLT: alu_res = {{(N-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_res = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic op, input logic [N-1:0] aa, input logic [N-1:0] bb);
    exp_t e;
    logic [2*N-1:0] p;
    p = (2*N)'(aa) * (2*N)'(bb);
    e.hi   = p[2*N-1:N];
    e.lo   = p[N-1:0];
    e.div0 = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    if (op) begin
      if (bb == '0) begin
        e.lo   = '1;
        e.hi   = aa;
        e.div0 = 1'b1;
      end else begin
        e.lo = aa / bb;
        e.hi = aa % bb;
      end
    end
`else
    if (op) e.div0 = 1'b0;
`endif
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},   32'(busy),   32'd0);
    check({tag, "_done"},   32'(done),   32'd0);
    check({tag, "_div0"},   32'(div0),   32'd0);
    check({tag, "_res_hi"}, 32'(res_hi), 32'd0);
    check({tag, "_res_lo"}, 32'(res_lo), 32'd0);
    check({tag, "_alu_a"},  32'(alu_a),  32'd0);
    check({tag, "_alu_b"},  32'(alu_b),  32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'(OP_ADD));
    check({tag, "_alu_ic"}, 32'({alu_inv, alu_c}), 32'd0);
  endtask

  task automatic apply_stimulus(input logic op, input logic [N-1:0] aa, input logic [N-1:0] bb);
    start  = 1'b1;
    op_sel = op;
    a      = aa;
    b      = bb;
    sb_q.push_back(model(op, aa, bb));
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_hi"},   32'(res_hi), 32'(e.hi));
      check({tag, "_lo"},   32'(res_lo), 32'(e.lo));
      check({tag, "_div0"}, 32'(div0),   32'(e.div0));
    end
  endtask

  // Runs one request; inj > 0 pulses a spurious start in that cycle of the operation.
  task automatic run_op(input string tag, input logic op, input logic [N-1:0] aa,
                        input logic [N-1:0] bb, input int inj);
    int cyc;
    @(negedge clk);
    apply_stimulus(op, aa, bb);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    while (!done && cyc < 4 * N) begin
      if (cyc == inj) begin
        start = 1'b1;
        a     = ~aa;
        b     = 8'h03;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(N + 1));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check_output(tag);
  endtask

  // Watches for any completion pulse over a window where none should occur.
  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check({tag, "_extra_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_sel = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    run_op("mul_13x11", 1'b0, 8'd13, 8'd11, 0);
    check("mul_13x11_lit", 32'({res_hi, res_lo}), 32'h008F);
    run_op("mul_ffxff", 1'b0, 8'hFF, 8'hFF, 0);
    check("mul_ffxff_lit", 32'({res_hi, res_lo}), 32'hFE01);

    @(negedge clk);
    check("hold_done_low", 32'(done), 32'd0);
    check("hold_busy_low", 32'(busy), 32'd0);
    check("hold_res", 32'({res_hi, res_lo}), 32'hFE01);

    run_op("mul_x0", 1'b0, 8'hA7, 8'h00, 0);
    run_op("mul_1x1", 1'b0, 8'h01, 8'h01, 0);
    for (int i = 0; i < 6; i++)
      run_op("mul_rand", 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);

`ifdef ALU_SEQ_DIV_EN
    run_op("div_100_7", 1'b1, 8'd100, 8'd7, 0);
    check("div_100_7_lit", 32'({div0, res_hi, res_lo}), 32'h0020E);
    run_op("div_5a_0", 1'b1, 8'h5A, 8'h00, 0);
    check("div_5a_0_lit", 32'({div0, res_hi, res_lo}), 32'h15AFF);
    run_op("div_ff_1", 1'b1, 8'hFF, 8'h01, 0);
    run_op("div_small", 1'b1, 8'h03, 8'hC8, 0);
    run_op("div_big", 1'b1, 8'hF0, 8'h81, 0);
    for (int i = 0; i < 6; i++)
      run_op("div_rand", 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 0);
    run_op("mul_after_div", 1'b0, 8'd9, 8'd0, 0);
    check("mul_after_div0_clr", 32'(div0), 32'd0);
`else
    run_op("op1_is_mul", 1'b1, 8'd100, 8'd7, 0);
    check("op1_is_mul_lit", 32'({res_hi, res_lo}), 32'h02BC);
    run_op("op1_b0_no_div0", 1'b1, 8'h5A, 8'h00, 0);
`endif

    run_op("ignore_start", 1'b0, 8'h21, 8'h07, 3);
    check("ignore_start_lit", 32'({res_hi, res_lo}), 32'h00E7);
    expect_no_done("ignore_start", N + 3);

    @(negedge clk);
    apply_stimulus(1'b0, 8'h37, 8'h29);
    void'(sb_q.pop_back());
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("mid_rst");
    expect_no_done("mid_rst", N + 3);
    run_op("after_rst", 1'b0, 8'h37, 8'h29, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
